// File: rtl/vga_timing_pkg.sv
// Nominal 640x480@60 timing constants and lock-FSM states shared by the sync decoder.
package vga_timing_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop sampler for an active-low sync line; idles high so reset never fakes an edge.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_s1,
    output logic o_fall,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_s1   = r_s1;
    assign o_fall = r_s2 & ~r_s1;
    assign o_rise = ~r_s2 & r_s1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and display enable from Hsync/Vsync alone, measures line/frame
// lengths, and runs a HUNT/CHECK/LOCKED state machine that flags timing errors once locked.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = vga_timing_pkg::H_VIS,
    parameter int H_FP   = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP   = vga_timing_pkg::H_BP,
    parameter int V_VIS  = vga_timing_pkg::V_VIS,
    parameter int V_FP   = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP   = vga_timing_pkg::V_BP
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Hsync,
    input  logic       Vsync,
    output logic [9:0] Xpixel,
    output logic [9:0] Ypixel,
    output logic       displayON,
    output logic       locked,
    output logic [9:0] lineLength,
    output logic [9:0] frameLines,
    output logic       hErr,
    output logic       vErr,
    output logic [7:0] errCount
);

    localparam logic [9:0] C_H_TOTAL = 10'(H_VIS + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] C_V_TOTAL = 10'(V_VIS + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] C_H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] C_H_END   = 10'(H_SYNC + H_BP + H_VIS - 1);
    localparam logic [9:0] C_V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] C_V_END   = 10'(V_SYNC + V_BP + V_VIS - 1);
    localparam logic [9:0] C_HSW     = 10'(H_SYNC);
    localparam logic [9:0] C_MAX     = 10'h3FF;

    function automatic logic [9:0] sat_inc10(input logic [9:0] a);
        return (a == C_MAX) ? a : a + 10'd1;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic        w_hsS1, w_hsFall, w_hsRise;
    logic        w_vsS1, w_vsFall, w_vsRise;
    logic [1:0]  w_unused_vs;

    logic [9:0]  r_hcnt, r_vcnt, r_wcnt;
    logic        r_hsWidthOk, r_vPending, r_bad;
    sync_state_t r_state, w_stateNext;
    logic        w_badNext, w_hErrNext, w_vErrNext;

    sync_edge u_hs (.i_clk(CLK), .i_rst(reset), .i_d(Hsync),
                    .o_s1(w_hsS1), .o_fall(w_hsFall), .o_rise(w_hsRise));
    sync_edge u_vs (.i_clk(CLK), .i_rst(reset), .i_d(Vsync),
                    .o_s1(w_vsS1), .o_fall(w_vsFall), .o_rise(w_vsRise));

    assign w_unused_vs = {w_vsS1, w_vsRise};

    logic [9:0] w_lineLen, w_frameLen;
    logic       w_boundary, w_lineGood, w_lost, w_hVis, w_vVis;

    // A vsync edge coinciding with the hsync edge closes the frame on that same line.
    assign w_lineLen  = r_hcnt + 10'd1;
    assign w_frameLen = r_vcnt + 10'd1;
    assign w_boundary = w_hsFall & (r_vPending | w_vsFall);
    assign w_lineGood = (w_lineLen == C_H_TOTAL) & r_hsWidthOk;
    assign w_lost     = (r_hcnt == C_MAX) & ~w_hsFall;
    assign w_hVis     = (r_hcnt >= C_H_START) && (r_hcnt <= C_H_END);
    assign w_vVis     = (r_vcnt >= C_V_START) && (r_vcnt <= C_V_END);
    assign locked     = (r_state == LOCKED);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= HUNT;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_badNext   = r_bad;
        w_hErrNext  = 1'b0;
        w_vErrNext  = 1'b0;
        if (w_lost) begin
            w_hErrNext  = (r_state == LOCKED);
            w_stateNext = HUNT;
        end else if (w_hsFall) begin
            case (r_state)
                HUNT: begin
                    if (w_boundary) begin
                        w_stateNext = CHECK;
                        w_badNext   = 1'b0;
                    end
                end
                CHECK: begin
                    if (w_boundary) begin
                        if (!r_bad && w_lineGood && (w_frameLen == C_V_TOTAL))
                            w_stateNext = LOCKED;
                        w_badNext = 1'b0;
                    end else begin
                        w_badNext = r_bad | ~w_lineGood;
                    end
                end
                LOCKED: begin
                    if (!w_lineGood) begin
                        w_hErrNext  = 1'b1;
                        w_stateNext = HUNT;
                    end
                    if (w_boundary && (w_frameLen != C_V_TOTAL)) begin
                        w_vErrNext  = 1'b1;
                        w_stateNext = HUNT;
                    end
                end
                default: w_stateNext = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_wcnt      <= '0;
            r_hsWidthOk <= 1'b0;
            r_vPending  <= 1'b0;
            r_bad       <= 1'b0;
            lineLength  <= '0;
            frameLines  <= '0;
            hErr        <= 1'b0;
            vErr        <= 1'b0;
            errCount    <= '0;
            Xpixel      <= '0;
            Ypixel      <= '0;
            displayON   <= 1'b0;
        end else begin
            r_hcnt <= w_hsFall ? 10'd0 : sat_inc10(r_hcnt);
            if (w_hsFall) lineLength <= w_lineLen;

            // Width counts every low s1 sample starting with the edge sample itself.
            if (w_hsFall)     r_wcnt <= 10'd1;
            else if (!w_hsS1) r_wcnt <= sat_inc10(r_wcnt);
            if (w_hsRise)     r_hsWidthOk <= (r_wcnt == C_HSW);

            if (w_boundary) begin
                frameLines <= w_frameLen;
                r_vcnt     <= '0;
                r_vPending <= 1'b0;
            end else begin
                if (w_hsFall) r_vcnt     <= sat_inc10(r_vcnt);
                if (w_vsFall) r_vPending <= 1'b1;
            end

            r_bad    <= w_badNext;
            hErr     <= w_hErrNext;
            vErr     <= w_vErrNext;
            errCount <= sat_add8(errCount, {1'b0, w_hErrNext} + {1'b0, w_vErrNext});

            Xpixel    <= w_hVis ? (r_hcnt - C_H_START) : 10'd0;
            Ypixel    <= w_vVis ? (r_vcnt - C_V_START) : 10'd0;
            displayON <= (r_state == LOCKED) & w_hVis & w_vVis;
        end
    end

endmodule
